ram_arbiter: RTL and testbench

Shares the single synchronous 16-bit data RAM between two requesters: the CPU datapath port (driven by the control unit's `ram_addr_sel`/`ram_write` path) and a DMA/loader port (ROM loader, peripheral DMA). It grants at most one access per cycle with CPU priority, a starvation guard for DMA, and locked DMA bursts of bounded length. It also routes the one-cycle-latency read data back to the requester that issued the read.

---
 rtl/ram_arbiter.sv | 140 ++++++++++++++
 tb/tb_ram_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-port arbiter for the shared single-port data RAM: CPU priority, locked DMA bursts, read-return routing.
// Build option RAM_ARB_STARVE_EN adds the DMA starvation guard; without it IDLE is fixed CPU priority.
module ram_arbiter #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned BURST_MAX    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic              dma_lock,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_write,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [DATA_W-1:0] rdata
);

  localparam logic [7:0] BURST_C  = BURST_MAX[7:0];
  localparam logic [3:0] STARVE_C = STARVE_LIMIT[3:0];

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_YIELD = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_burst_cnt;
  logic [7:0]  w_burst_cnt_nxt;
  logic [7:0]  w_burst_inc;
  logic        r_cpu_rvalid;
  logic        r_dma_rvalid;
  logic        w_cpu_gnt;
  logic        w_dma_gnt;
  logic        w_dma_prio;
  logic        w_starve_hit;

`ifdef RAM_ARB_STARVE_EN
  logic [3:0] r_starve;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (!dma_req || w_dma_gnt) begin
      r_starve <= '0;
    end else if (r_starve != STARVE_C) begin
      r_starve <= r_starve + 4'd1;
    end
  end

  assign w_starve_hit = (r_starve == STARVE_C);
`else
  assign w_starve_hit = 1'b0 && (STARVE_C != 4'd0);
`endif

  // Priority selection; the losing port only wins when the favoured one is idle.
  always_comb begin
    w_dma_prio = 1'b0;
    unique case (r_state)
      S_IDLE:  w_dma_prio = w_starve_hit;
      S_BURST: w_dma_prio = 1'b1;
      default: w_dma_prio = 1'b0;
    endcase
    if (w_dma_prio) begin
      w_dma_gnt = rst_n & dma_req;
      w_cpu_gnt = rst_n & cpu_req & ~dma_req;
    end else begin
      w_cpu_gnt = rst_n & cpu_req;
      w_dma_gnt = rst_n & dma_req & ~cpu_req;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_burst_cnt_nxt = r_burst_cnt;
    w_burst_inc     = r_burst_cnt + 8'd1;
    unique case (r_state)
      S_IDLE: begin
        if (w_dma_gnt && dma_lock) begin
          w_state_nxt     = S_BURST;
          w_burst_cnt_nxt = 8'd1;
        end
      end
      S_BURST: begin
        // A lock drop on the final grant ends the burst without a yield slot.
        if (!dma_req || !dma_lock) begin
          w_state_nxt     = S_IDLE;
          w_burst_cnt_nxt = '0;
        end else if (w_burst_inc == BURST_C) begin
          w_state_nxt     = S_YIELD;
          w_burst_cnt_nxt = '0;
        end else begin
          w_burst_cnt_nxt = w_burst_inc;
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_burst_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_burst_cnt  <= '0;
      r_cpu_rvalid <= 1'b0;
      r_dma_rvalid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_burst_cnt  <= w_burst_cnt_nxt;
      r_cpu_rvalid <= w_cpu_gnt & ~cpu_we;
      r_dma_rvalid <= w_dma_gnt & ~dma_we;
    end
  end

  assign cpu_gnt    = w_cpu_gnt;
  assign dma_gnt    = w_dma_gnt;
  assign cpu_rvalid = r_cpu_rvalid;
  assign dma_rvalid = r_dma_rvalid;
  assign ram_addr   = w_dma_gnt ? dma_addr : cpu_addr;
  assign ram_din    = w_dma_gnt ? dma_wdata : cpu_wdata;
  assign ram_write  = (w_cpu_gnt & cpu_we) | (w_dma_gnt & dma_we);
  assign rdata      = ram_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: vector table, directed burst/starve/reset sequences, random traffic vs model.
module tb_ram_arbiter;
  localparam int SL = 4;
  localparam int BM = 8;
`ifdef RAM_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, dma_req, dma_we, dma_lock;
  logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, ram_write;
  logic [15:0] ram_addr, ram_din, ram_dout, rdata;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(SL), .BURST_MAX(BM)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_write(ram_write),
    .ram_dout(ram_dout), .rdata(rdata)
  );

  // RAM stand-in: write at the edge, registered read-first output
  logic [15:0] ram_mem [256];
  always @(posedge clk) begin
    if (ram_write) ram_mem[ram_addr[7:0]] <= ram_din;
    ram_dout <= ram_mem[ram_addr[7:0]];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: burst length so far, pending yield turn, consecutive DMA losses
  int          m_burst, m_lost;
  bit          m_yield, m_crv, m_drv, m_rknown;
  logic [15:0] m_rdata;
  logic [15:0] ref_mem [256];
  bit          ref_wr  [256];

  function automatic void decide(output bit cg, output bit dg);
    bit dma_first;
    cg = 1'b0;
    dg = 1'b0;
    if (rst_n !== 1'b1) return;
    if (m_yield)          dma_first = 1'b0;
    else if (m_burst > 0) dma_first = 1'b1;
    else                  dma_first = STARVE && (m_lost == SL);
    if (dma_first) begin
      dg = dma_req;
      cg = cpu_req && !dma_req;
    end else begin
      cg = cpu_req;
      dg = dma_req && !cpu_req;
    end
  endfunction

  task automatic model_check();
    bit cg, dg, wr;
    decide(cg, dg);
    wr = (cg && cpu_we) || (dg && dma_we);
    check("cpu_gnt", cpu_gnt, cg);
    check("dma_gnt", dma_gnt, dg);
    check("ram_write", ram_write, wr);
    check("ram_addr", ram_addr, dg ? dma_addr : cpu_addr);
    if (wr) check("ram_din", ram_din, dg ? dma_wdata : cpu_wdata);
    check("cpu_rvalid", cpu_rvalid, rst_n && m_crv);
    check("dma_rvalid", dma_rvalid, rst_n && m_drv);
    if (rst_n && (m_crv || m_drv) && m_rknown) check("rdata", rdata, m_rdata);
  endtask

  task automatic model_update();
    bit cg, dg, we;
    logic [7:0] a;
    decide(cg, dg);
    if (rst_n !== 1'b1) begin
      m_burst = 0; m_yield = 0; m_lost = 0; m_crv = 0; m_drv = 0;
      return;
    end
    if (cg || dg) begin
      a  = dg ? dma_addr[7:0] : cpu_addr[7:0];
      we = dg ? dma_we : cpu_we;
      if (!we) begin
        m_rdata  = ref_mem[a];
        m_rknown = ref_wr[a];
      end else begin
        ref_mem[a] = dg ? dma_wdata : cpu_wdata;
        ref_wr[a]  = 1'b1;
      end
    end
    m_crv = cg && !cpu_we;
    m_drv = dg && !dma_we;
    if (STARVE) m_lost = (dma_req && !dg) ? ((m_lost < SL) ? m_lost + 1 : SL) : 0;
    if (m_yield) begin
      m_yield = 0;
      m_burst = 0;
    end else if (m_burst > 0) begin
      if (!dma_req || !dma_lock) m_burst = 0;
      else begin
        m_burst++;
        if (m_burst == BM) begin
          m_burst = 0;
          m_yield = 1;
        end
      end
    end else if (dg && dma_lock) begin
      m_burst = 1;
    end
  endtask

  // Values captured at the negedge of the last tick
  bit          s_cg, s_dg, s_wr, s_crv, s_drv;
  logic [15:0] s_addr;

  task automatic tick();
    @(negedge clk);
    s_cg = cpu_gnt; s_dg = dma_gnt; s_wr = ram_write;
    s_crv = cpu_rvalid; s_drv = dma_rvalid; s_addr = ram_addr;
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_idle();
    cpu_req = 0; cpu_we = 0; dma_req = 0; dma_we = 0; dma_lock = 0;
  endtask

  // Both ports request continuously from IDLE with no starvation history
  task automatic starve_pattern(input int n, input string tag);
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    dma_req = 1; dma_we = 0; dma_lock = 0; dma_addr = 16'h0020;
    for (int i = 0; i < n; i++) begin
      bit exp_dma;
      tick();
      exp_dma = STARVE && (i % 5 == 4);
      check({tag, "_dma"}, s_dg, exp_dma);
      check({tag, "_cpu"}, s_cg, !exp_dma);
    end
    set_idle();
    tick();
  endtask

  typedef struct {
    bit creq, cwe; logic [15:0] caddr, cwd;
    bit dreq, dwe; logic [15:0] daddr, dwd;
    bit ecg, edg, ewr, ecrv, edrv; logic [15:0] erd;
  } vec_t;

  function automatic vec_t mk(bit creq, bit cwe, logic [15:0] caddr, logic [15:0] cwd,
                              bit dreq, bit dwe, logic [15:0] daddr, logic [15:0] dwd,
                              bit ecg, bit edg, bit ewr, bit ecrv, bit edrv, logic [15:0] erd);
    vec_t v;
    v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
    v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd;
    v.ecg = ecg; v.edg = edg; v.ewr = ewr; v.ecrv = ecrv; v.edrv = edrv; v.erd = erd;
    return v;
  endfunction

  initial begin
    vec_t tv [13];
    int   cnt;
    tv[0]  = mk(0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,0, 0,0,16'h0000);
    tv[1]  = mk(1,1,16'h0010,16'h1234, 0,0,16'h0000,16'h0000, 1,0,1, 0,0,16'h0000);
    tv[2]  = mk(1,0,16'h0010,16'h0000, 0,0,16'h0000,16'h0000, 1,0,0, 0,0,16'h0000);
    tv[3]  = mk(0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,0, 1,0,16'h1234);
    tv[4]  = mk(0,0,16'h0000,16'h0000, 1,1,16'h0020,16'hBEEF, 0,1,1, 0,0,16'h0000);
    tv[5]  = mk(1,0,16'h0020,16'h0000, 1,0,16'h0010,16'h0000, 1,0,0, 0,0,16'h0000);
    tv[6]  = mk(0,0,16'h0000,16'h0000, 1,0,16'h0010,16'h0000, 0,1,0, 1,0,16'hBEEF);
    tv[7]  = mk(0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,0, 0,1,16'h1234);
    tv[8]  = mk(1,1,16'h0030,16'h5555, 1,1,16'h0031,16'h6666, 1,0,1, 0,0,16'h0000);
    tv[9]  = mk(0,0,16'h0000,16'h0000, 1,1,16'h0031,16'h6666, 0,1,1, 0,0,16'h0000);
    tv[10] = mk(1,0,16'h0031,16'h0000, 1,0,16'h0030,16'h0000, 1,0,0, 0,0,16'h0000);
    tv[11] = mk(0,0,16'h0000,16'h0000, 1,0,16'h0030,16'h0000, 0,1,0, 1,0,16'h6666);
    tv[12] = mk(0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,0, 0,1,16'h5555);

    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = '0;
      ref_wr[i]  = 1'b0;
    end
    m_burst = 0; m_yield = 0; m_lost = 0; m_crv = 0; m_drv = 0; m_rknown = 0; m_rdata = '0;
    cpu_addr = '0; cpu_wdata = '0; dma_addr = '0; dma_wdata = '0;
    set_idle();
    rst_n = 0;
    #1;
    tick();
    cpu_req = 1; dma_req = 1;
    tick();
    check("reset_gnt", {s_cg, s_dg, s_wr}, 3'b000);
    check("reset_rvalid", {s_crv, s_drv}, 2'b00);
    set_idle();
    rst_n = 1;
    tick();

    for (int i = 0; i < 13; i++) begin
      cpu_req = tv[i].creq; cpu_we = tv[i].cwe; cpu_addr = tv[i].caddr; cpu_wdata = tv[i].cwd;
      dma_req = tv[i].dreq; dma_we = tv[i].dwe; dma_addr = tv[i].daddr; dma_wdata = tv[i].dwd;
      dma_lock = 0;
      @(negedge clk);
      check("tv_cpu_gnt", cpu_gnt, tv[i].ecg);
      check("tv_dma_gnt", dma_gnt, tv[i].edg);
      check("tv_ram_write", ram_write, tv[i].ewr);
      check("tv_rvalid", {cpu_rvalid, dma_rvalid}, {tv[i].ecrv, tv[i].edrv});
      if (tv[i].ecrv || tv[i].edrv) check("tv_rdata", rdata, tv[i].erd);
      model_check();
      @(posedge clk);
      model_update();
      #1;
    end
    set_idle();
    tick();

    starve_pattern(15, "starve");

    // Locked 12-read burst with the CPU requesting from the second cycle on
    cnt = 0;
    for (int i = 0; i < 40 && cnt < 12; i++) begin
      cpu_req = (i > 0) && (i < 24); cpu_we = 0; cpu_addr = 16'h0010;
      dma_req = 1; dma_we = 0; dma_lock = 1; dma_addr = 16'h0100 + 16'(cnt);
      tick();
      if (i < 8)  check("burst_dma", s_dg, 1'b1);
      if (i == 8) check("yield_cpu", s_cg, 1'b1);
      if (STARVE && i >= 9 && i <= 11) check("post_yield_cpu", s_cg, 1'b1);
      if (STARVE && i == 12) check("reenter_dma", s_dg, 1'b1);
      if (s_dg) cnt++;
    end
    check("burst12_done", cnt, 12);
    set_idle();
    tick();

    // Three locked writes, lock dropped on the third
    for (int i = 0; i < 3; i++) begin
      dma_req = 1; dma_we = 1; dma_lock = (i < 2);
      dma_addr = 16'h00A0 + 16'(i); dma_wdata = 16'hD000 + 16'(i);
      tick();
      check("lockdrop_dma", s_dg, 1'b1);
    end
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h00A0;
    dma_we = 0; dma_lock = 0; dma_addr = 16'h00A1;
    tick();
    check("lockdrop_idle_cpu", s_cg, 1'b1);
    set_idle();
    tick();
    tick();

    // Lock dropped on the BURST_MAX-th grant must not produce a yield slot
    for (int i = 0; i < BM; i++) begin
      dma_req = 1; dma_we = 0; dma_lock = (i < BM - 1); dma_addr = 16'h0040 + 16'(i);
      tick();
      check("maxdrop_dma", s_dg, 1'b1);
    end
    dma_lock = 1; dma_addr = 16'h0050;
    tick();
    check("maxdrop_reenter", s_dg, 1'b1);
    cpu_req = 1; dma_addr = 16'h0051;
    tick();
    check("maxdrop_in_burst", s_dg, 1'b1);
    set_idle();
    tick();

    // Reset pulse during the 5th burst read
    for (int i = 0; i < 4; i++) begin
      dma_req = 1; dma_we = 0; dma_lock = 1; dma_addr = 16'h0060 + 16'(i);
      tick();
      check("prerst_dma", s_dg, 1'b1);
    end
    dma_addr = 16'h0064;
    rst_n = 0;
    tick();
    check("rst_dma_gnt", s_dg, 1'b0);
    check("rst_ram_write", s_wr, 1'b0);
    check("rst_rvalid", {s_crv, s_drv}, 2'b00);
    rst_n = 1;
    starve_pattern(10, "postrst");

    // Both idle: no grants, address follows the CPU port
    for (int i = 0; i < 10; i++) begin
      cpu_addr = 16'($urandom);
      dma_addr = 16'($urandom);
      tick();
      check("idle_gnt", {s_cg, s_dg, s_wr}, 3'b000);
      check("idle_addr", s_addr, cpu_addr);
    end

    for (int i = 0; i < 500; i++) begin
      if (!cpu_req || s_cg || !rst_n) begin
        cpu_req = ($urandom_range(0, 99) < 60); cpu_we = $urandom_range(0, 1);
        cpu_addr = 16'($urandom_range(0, 15)); cpu_wdata = 16'($urandom);
      end
      if (!dma_req || s_dg || !rst_n) begin
        dma_req = ($urandom_range(0, 99) < 70); dma_we = $urandom_range(0, 1);
        dma_addr = 16'($urandom_range(0, 15)); dma_wdata = 16'($urandom);
      end
      dma_lock = ($urandom_range(0, 99) < 80);
      rst_n = ($urandom_range(0, 149) != 0);
      tick();
    end
    rst_n = 1;
    set_idle();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
